// File: rtl/mul_div_unit_pkg.sv
// Shared constants for the multiply/divide unit: default width, op codes,
// FSM state encoding and small op-decode helpers.
package mul_div_unit_pkg;

    localparam int MDU_WIDTH = 32;

    localparam logic [1:0] MDU_MULTU = 2'b00;
    localparam logic [1:0] MDU_MULT  = 2'b01;
    localparam logic [1:0] MDU_DIVU  = 2'b10;
    localparam logic [1:0] MDU_DIV   = 2'b11;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return op[0];
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Control-unit <-> multiply/divide unit bundle: operands, launch, MTHI/MTLO
// writes, and the Busy/Done/HI/LO return path.
interface mul_div_unit_if import mul_div_unit_pkg::*; #(
    parameter int WIDTH = MDU_WIDTH
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [1:0]       Op;
    logic             Start;
    logic             WrHi;
    logic             WrLo;
    logic [WIDTH-1:0] WrData;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output A, B, Op, Start, WrHi, WrLo, WrData,
        input  Busy, Done, HI, LO
    );

    modport slave (
        input  A, B, Op, Start, WrHi, WrLo, WrData,
        output Busy, Done, HI, LO
    );
endinterface

// File: rtl/mdu_step.sv
// One iteration of the shift-add multiply / restoring divide datapath.
// The accumulator holds {hi, lo}: for multiply, the partial product high half
// and the not-yet-consumed multiplier bits; for divide, the partial remainder
// and the dividend bits being shifted into it. The quotient bit is returned
// separately (acc_nxt[0] is left clear in divide mode) and merged by the caller.
module mdu_step import mul_div_unit_pkg::*; #(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic                 div,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     mag,
    output logic [2*WIDTH-1:0]   acc_nxt,
    output logic                 qbit
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    // Multiply adds the multiplicand under the current multiplier bit and
    // shifts right; divide shifts the next dividend bit into the remainder
    // and keeps the trial difference only when it did not go negative.
    always_comb begin
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mag : '0)};
        trial   = acc[2*WIDTH-1:WIDTH-1];
        diff    = trial - {1'b0, mag};
        qbit    = 1'b0;
        acc_nxt = '0;
        if (!div) begin
            acc_nxt = {sum, acc[WIDTH-1:1]};
        end else begin
            qbit    = ~diff[WIDTH];
            acc_nxt = {(qbit ? diff[WIDTH-1:0] : trial[WIDTH-1:0]),
                       acc[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO pair.
// Operands are converted to magnitudes at launch, iterated one bit per cycle
// for WIDTH cycles, then sign-corrected in a single FIX cycle that writes HI/LO.
module mul_div_unit import mul_div_unit_pkg::*; #(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    mul_div_unit_if.slave bus
);

    localparam int              CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    logic [1:0]           state;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     mag_q;
    logic [WIDTH-1:0]     a_q;
    logic                 div_q;
    logic                 neg_q;
    logic                 neg_r;
    logic                 dbz_q;
    logic                 done_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;

    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;
    logic [2*WIDTH-1:0]   step_acc;
    logic                 step_q;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     fix_hi;
    logic [WIDTH-1:0]     fix_lo;

    // Launch-time operand decode: signed ops work on magnitudes.
    always_comb begin
        a_neg = op_is_signed(bus.Op) & bus.A[WIDTH-1];
        b_neg = op_is_signed(bus.Op) & bus.B[WIDTH-1];
        abs_a = a_neg ? -bus.A : bus.A;
        abs_b = b_neg ? -bus.B : bus.B;
    end

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .div     (div_q),
        .acc     (acc),
        .mag     (mag_q),
        .acc_nxt (step_acc),
        .qbit    (step_q)
    );

    // Sign correction of the finished magnitude result; divide-by-zero
    // bypasses it so that HI returns the raw dividend and LO all ones.
    always_comb begin
        prod_fix = neg_q ? -acc : acc;
        fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo   = prod_fix[WIDTH-1:0];
        if (div_q) begin
            fix_lo = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            fix_hi = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            if (dbz_q) begin
                fix_hi = a_q;
                fix_lo = '1;
            end
        end
    end

    // FSM, iteration counter and operand/accumulator registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            mag_q  <= '0;
            a_q    <= '0;
            div_q  <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dbz_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        div_q <= op_is_div(bus.Op);
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        dbz_q <= op_is_div(bus.Op) && (bus.B == '0);
                        a_q   <= bus.A;
                        if (op_is_div(bus.Op)) begin
                            acc   <= {{WIDTH{1'b0}}, abs_a};
                            mag_q <= abs_b;
                        end else begin
                            acc   <= {{WIDTH{1'b0}}, abs_b};
                            mag_q <= abs_a;
                        end
                        cnt   <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc <= step_acc | {{(2*WIDTH-1){1'b0}}, step_q};
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) state <= FIX;
                end
                FIX: begin
                    state  <= IDLE;
                    done_q <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // HI/LO: result writeback from FIX, MTHI/MTLO only while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (state == FIX) begin
            hi_q <= fix_hi;
            lo_q <= fix_lo;
        end else if (state == IDLE) begin
            if (bus.WrHi) hi_q <= bus.WrData;
            if (bus.WrLo) lo_q <= bus.WrData;
        end
    end

    assign bus.Busy = (state != IDLE);
    assign bus.Done = done_q;
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;

endmodule
